comp_fir_cfg_ctrl: RTL and testbench

Reconfiguration sequencer for the compensation FIR: sits between the CIC output and the compensation FIR and owns the FIR's `decim_sel`, `comp_enable` and `sync_reset` inputs. A configuration change is applied only after the FIR delay line has been flushed with zeros. The FIR's start-up transient is then masked from downstream, so a decimation or bypass change never produces mixed-coefficient samples at the output. Input samples that arrive during reconfiguration are dropped and counted.

---
 rtl/comp_fir_cfg_ctrl.sv | 155 +++++++++++++++
 tb/tb_comp_fir_cfg_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/comp_fir_cfg_ctrl.sv
// rtl/comp_fir_cfg_ctrl.sv - compensation FIR reconfiguration sequencer
// Flushes the FIR with zeros, applies the new config, then masks the start-up transient.
module comp_fir_cfg_ctrl #(
    parameter int W         = 28,
    parameter int FLUSH_LEN = 22,
    parameter int DROP_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              cfg_req,
    input  logic [2:0]        cfg_decim_sel,
    input  logic              cfg_comp_enable,
    output logic              cfg_busy,
    output logic              cfg_done,
    input  logic              s_valid,
    input  logic [W-1:0]      s_sample,
    output logic              fir_in_valid,
    output logic [W-1:0]      fir_in_sample,
    output logic [2:0]        fir_decim_sel,
    output logic              fir_comp_enable,
    output logic              fir_sync_reset,
    input  logic              fir_out_valid,
    input  logic [W-1:0]      fir_out_sample,
    output logic              m_valid,
    output logic [W-1:0]      m_sample,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_APPLY, S_WARMUP} state_t;

    localparam int FCW = $clog2(FLUSH_LEN + 1);
    localparam int NW  = 5;

    state_t              r_state;
    logic [FCW-1:0]      r_flush_cnt;
    logic [2:0]          r_pend_sel;
    logic                r_pend_en;
    logic [NW-1:0]       r_warm_cnt;
    logic [NW-1:0]       r_warm_n;
    logic [2:0]          r_fir_decim_sel;
    logic                r_fir_comp_enable;
    logic                r_fir_sync_reset;
    logic                r_cfg_busy;
    logic                r_cfg_done;
    logic [DROP_W-1:0]   r_drop_cnt;

    logic [2:0]          w_req_sel;
    logic [NW-1:0]       w_mask_n;
    logic                w_drop;

    assign w_req_sel = (cfg_decim_sel > 3'd4) ? 3'd4 : cfg_decim_sel;
    assign w_drop    = s_valid && ((r_state == S_FLUSH) || (r_state == S_APPLY));

    // Transient length depends on the tap count of the newly selected FIR mode.
    always_comb begin
        w_mask_n = '0;
        if (r_pend_en && (r_pend_sel != 3'd0)) begin
            w_mask_n = (r_pend_sel == 3'd1) ? NW'(21) : NW'(22);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_RUN;
            r_flush_cnt       <= '0;
            r_pend_sel        <= '0;
            r_pend_en         <= 1'b0;
            r_warm_cnt        <= '0;
            r_warm_n          <= '0;
            r_fir_decim_sel   <= '0;
            r_fir_comp_enable <= 1'b0;
            r_fir_sync_reset  <= 1'b0;
            r_cfg_busy        <= 1'b0;
            r_cfg_done        <= 1'b0;
            r_drop_cnt        <= '0;
        end else if (clk_enable) begin
            r_cfg_done       <= 1'b0;
            r_fir_sync_reset <= 1'b0;
            if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
            case (r_state)
                S_RUN: begin
                    if (cfg_req) begin
                        r_pend_sel  <= w_req_sel;
                        r_pend_en   <= cfg_comp_enable;
                        r_flush_cnt <= '0;
                        r_cfg_busy  <= 1'b1;
                        r_state     <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == FCW'(FLUSH_LEN - 1)) begin
                        r_fir_sync_reset <= 1'b1;
                        r_state          <= S_APPLY;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + FCW'(1);
                    end
                end
                S_APPLY: begin
                    r_fir_decim_sel   <= r_pend_sel;
                    r_fir_comp_enable <= r_pend_en;
                    r_warm_cnt        <= '0;
                    r_warm_n          <= w_mask_n;
                    if (w_mask_n == '0) begin
                        r_cfg_busy <= 1'b0;
                        r_cfg_done <= 1'b1;
                        r_state    <= S_RUN;
                    end else begin
                        r_state <= S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    if (fir_out_valid) begin
                        if (r_warm_cnt == r_warm_n - NW'(1)) begin
                            r_cfg_busy <= 1'b0;
                            r_cfg_done <= 1'b1;
                            r_state    <= S_RUN;
                        end else begin
                            r_warm_cnt <= r_warm_cnt + NW'(1);
                        end
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    always_comb begin
        fir_in_valid  = 1'b0;
        fir_in_sample = (r_state == S_FLUSH) ? '0 : s_sample;
        m_valid       = 1'b0;
        if (clk_enable) begin
            case (r_state)
                S_RUN: begin
                    fir_in_valid = s_valid;
                    m_valid      = fir_out_valid;
                end
                S_FLUSH:  fir_in_valid = 1'b1;
                S_WARMUP: fir_in_valid = s_valid;
                default:  fir_in_valid = 1'b0;
            endcase
        end
    end

    assign m_sample        = fir_out_sample;
    assign fir_decim_sel   = r_fir_decim_sel;
    assign fir_comp_enable = r_fir_comp_enable;
    assign fir_sync_reset  = r_fir_sync_reset;
    assign cfg_busy        = r_cfg_busy;
    assign cfg_done        = r_cfg_done;
    assign drop_cnt        = r_drop_cnt;

endmodule

// File: tb/tb_comp_fir_cfg_ctrl.sv
// tb/tb_comp_fir_cfg_ctrl.sv - scoreboard bench for comp_fir_cfg_ctrl
// A stand-in FIR (1-cycle latency, +7 offset) closes the loop; expectations come from a phase-count model.
module tb_comp_fir_cfg_ctrl;

    localparam int W         = 28;
    localparam int FLUSH_LEN = 22;
    localparam int DROP_W    = 5;
    localparam int DROP_MAX  = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clk_enable = 1'b0;
    logic              cfg_req = 1'b0;
    logic [2:0]        cfg_decim_sel = 3'd0;
    logic              cfg_comp_enable = 1'b0;
    logic              cfg_busy;
    logic              cfg_done;
    logic              s_valid = 1'b0;
    logic [W-1:0]      s_sample = '0;
    logic              fir_in_valid;
    logic [W-1:0]      fir_in_sample;
    logic [2:0]        fir_decim_sel;
    logic              fir_comp_enable;
    logic              fir_sync_reset;
    logic              fir_out_valid;
    logic [W-1:0]      fir_out_sample;
    logic              m_valid;
    logic [W-1:0]      m_sample;
    logic [DROP_W-1:0] drop_cnt;

    comp_fir_cfg_ctrl #(.W(W), .FLUSH_LEN(FLUSH_LEN), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .cfg_req(cfg_req), .cfg_decim_sel(cfg_decim_sel), .cfg_comp_enable(cfg_comp_enable),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .s_valid(s_valid), .s_sample(s_sample),
        .fir_in_valid(fir_in_valid), .fir_in_sample(fir_in_sample),
        .fir_decim_sel(fir_decim_sel), .fir_comp_enable(fir_comp_enable),
        .fir_sync_reset(fir_sync_reset),
        .fir_out_valid(fir_out_valid), .fir_out_sample(fir_out_sample),
        .m_valid(m_valid), .m_sample(m_sample), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            fir_out_valid  <= 1'b0;
            fir_out_sample <= '0;
        end else if (clk_enable) begin
            fir_out_valid  <= fir_in_valid;
            fir_out_sample <= fir_in_sample + W'(7);
        end
    end

    typedef struct {
        bit         in_v;
        bit         m_v;
        bit         busy;
        bit         done;
        bit         sync;
        bit         cen;
        logic [2:0] sel;
        int         drop;
    } exp_t;

    exp_t         st_q[$];
    logic [W-1:0] in_q[$];
    logic [W-1:0] out_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    // Reference model: remaining flush cycles, pending apply, remaining masked outputs.
    int           m_flush, m_mask, m_drop;
    bit           m_apply, m_warm, m_done, m_sync, m_en, m_pen, m_pipe_v;
    logic [2:0]   m_sel, m_psel;
    logic [W-1:0] m_pipe_s;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flush = 0; m_mask = 0; m_drop = 0;
        m_apply = 0; m_warm = 0; m_done = 0; m_sync = 0;
        m_en = 0; m_pen = 0; m_pipe_v = 0;
        m_sel = 3'd0; m_psel = 3'd0; m_pipe_s = '0;
        st_q.delete(); in_q.delete(); out_q.delete();
    endtask

    task automatic step(input bit rst, input bit ce, input bit req, input bit sv,
                        input logic [2:0] sel, input bit en, input logic [W-1:0] samp);
        exp_t         e;
        bit           in_v;
        logic [W-1:0] in_s;
        int           n;
        @(negedge clk);
        reset = rst; clk_enable = ce; cfg_req = req; s_valid = sv;
        cfg_decim_sel = sel; cfg_comp_enable = en; s_sample = samp;
        if (rst) begin
            model_reset();
            return;
        end
        e.busy = (m_flush > 0) || m_apply || m_warm;
        e.done = m_done; e.sync = m_sync; e.sel = m_sel; e.cen = m_en; e.drop = m_drop;
        e.in_v = 0; e.m_v = 0;
        if (!ce) begin
            st_q.push_back(e);
            return;
        end
        in_v = 0; in_s = samp; m_done = 0; m_sync = 0;
        if (m_flush > 0) begin
            in_v = 1; in_s = '0;
            if (sv && m_drop < DROP_MAX) m_drop++;
            m_flush--;
            if (m_flush == 0) begin m_apply = 1; m_sync = 1; end
        end else if (m_apply) begin
            if (sv && m_drop < DROP_MAX) m_drop++;
            m_apply = 0; m_sel = m_psel; m_en = m_pen;
            n = (m_pen && m_psel != 0) ? ((m_psel == 1) ? 21 : 22) : 0;
            if (n == 0) m_done = 1;
            else begin m_warm = 1; m_mask = n; end
        end else if (m_warm) begin
            in_v = sv;
            if (m_pipe_v) begin
                m_mask--;
                if (m_mask == 0) begin m_warm = 0; m_done = 1; end
            end
        end else begin
            in_v = sv;
            if (m_pipe_v) begin e.m_v = 1; out_q.push_back(m_pipe_s); end
            if (req) begin
                m_psel = (sel > 4) ? 3'd4 : sel;
                m_pen = en; m_flush = FLUSH_LEN;
            end
        end
        e.in_v = in_v;
        if (in_v) in_q.push_back(in_s);
        m_pipe_v = in_v; m_pipe_s = in_s + W'(7);
        st_q.push_back(e);
    endtask

    task automatic run_until_done(input int budget);
        int k;
        k = 0;
        while (!m_done && k < budget) begin
            step(0, 1, 0, 1, 3'd0, 0, W'($urandom));
            k++;
        end
        chk("done_within_budget", (k < budget), 1);
    endtask

    always @(negedge clk) begin
        exp_t         e;
        logic [W-1:0] xs;
        #2;
        if (!reset) begin
            if (st_q.size() == 0) begin
                chk("status_queue_nonempty", 0, 1);
            end else begin
                e = st_q.pop_front();
                chk("fir_in_valid", fir_in_valid, e.in_v);
                chk("m_valid", m_valid, e.m_v);
                chk("cfg_busy", cfg_busy, e.busy);
                chk("cfg_done", cfg_done, e.done);
                chk("fir_sync_reset", fir_sync_reset, e.sync);
                chk("fir_decim_sel", fir_decim_sel, e.sel);
                chk("fir_comp_enable", fir_comp_enable, e.cen);
                chk("drop_cnt", drop_cnt, e.drop);
                if (e.in_v && in_q.size() > 0) begin
                    xs = in_q.pop_front();
                    if (fir_in_valid) chk("fir_in_sample", fir_in_sample, xs);
                end
                if (e.m_v && out_q.size() > 0) begin
                    xs = out_q.pop_front();
                    if (m_valid) chk("m_sample", m_sample, xs);
                end
            end
        end
    end

    initial begin
        int k;
        model_reset();
        repeat (3) step(1, 1, 0, 0, 3'd0, 0, '0);
        repeat (10) step(0, 1, 0, 1, 3'd0, 0, W'(100));
        // sel=2, compensation on: 22 zeros, apply, 22 masked outputs
        step(0, 1, 1, 1, 3'd2, 1, W'(100));
        run_until_done(80);
        repeat (5) step(0, 1, 0, 1, 3'd0, 0, W'(100));
        // sel=0: no warm-up, drop counter saturates in this run
        step(0, 1, 1, 1, 3'd0, 1, W'(55));
        run_until_done(40);
        repeat (5) step(0, 1, 0, 1, 3'd0, 0, W'($urandom));
        // sel=7 clamps to 4; a second request mid-flush is ignored
        step(0, 1, 1, 1, 3'd7, 1, W'(1));
        repeat (6) step(0, 1, 0, 1, 3'd0, 0, W'($urandom));
        step(0, 1, 1, 1, 3'd1, 0, W'(2));
        run_until_done(80);
        // request in the cfg_done cycle is accepted
        step(0, 1, 1, 1, 3'd2, 0, W'(3));
        run_until_done(40);
        // reset during warm-up
        step(0, 1, 1, 1, 3'd1, 1, W'(4));
        k = 0;
        while (!(m_warm && m_mask < 10) && k < 60) begin
            step(0, 1, 0, 1, 3'd0, 0, W'($urandom)); k++;
        end
        chk("reached_warmup", m_warm, 1);
        step(1, 1, 0, 1, 3'd0, 0, '0);
        repeat (5) step(0, 1, 0, 1, 3'd0, 0, W'($urandom));
        // clk_enable low for 5 flush cycles
        step(0, 1, 1, 1, 3'd3, 1, W'(5));
        repeat (5) step(0, 1, 0, 1, 3'd0, 0, W'($urandom));
        repeat (5) step(0, 0, 0, 1, 3'd0, 0, W'($urandom));
        run_until_done(80);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 999) < 3), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 99) < 3), $urandom_range(0, 1),
                 3'($urandom_range(0, 7)), $urandom_range(0, 1), W'($urandom));
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        chk("status_queue_drained", st_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
